// File: rtl/qdi_bin_bridge.sv
// qdi_bin_bridge: clocked bridge between synchronous binary logic and
// 4-phase return-to-zero QDI channels. It has two transmitters: T (1-of-2)
// and C (1-of-4). It has one receiver: R (1-of-2 to binary).

// Generic binary -> 1-of-N transmitter with enable synchronizer and go-edge capture
module qdi_tx #(
    parameter int W           = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      data,
    input  logic              go,
    input  logic              e,
    output logic [(1<<W)-1:0] rails
);
    localparam int N = 1 << W;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT_ACK,
        TX_WAIT_EN
    } tx_state_t;

    logic [SYNC_STAGES-1:0] e_sync;
    logic                   e_s;
    logic                   go_d;
    logic                   go_rise;
    tx_state_t              state, state_n;
    logic                   pending, pending_n;
    logic [W-1:0]           data_q, data_n;
    logic [N-1:0]           rails_n;

    // Bring the receiver's asynchronous enable into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_sync <= '0;
        end else begin
            e_sync[0] <= e;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                e_sync[i] <= e_sync[i-1];
            end
        end
    end

    assign e_s = e_sync[SYNC_STAGES-1];

    // Remember last go level so a held-high request counts as a single token
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_d <= 1'b0;
        end else begin
            go_d <= go;
        end
    end

    assign go_rise = go & ~go_d;

    // Handshake state, pending request, captured data and registered rails
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            pending <= 1'b0;
            data_q  <= '0;
            rails   <= '0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            data_q  <= data_n;
            rails   <= rails_n;
        end
    end

    // Next-state logic: capture a request only when idle with nothing queued
    always_comb begin
        state_n   = state;
        pending_n = pending;
        data_n    = data_q;
        rails_n   = rails;

        if (go_rise && !pending && (state == TX_IDLE)) begin
            pending_n = 1'b1;
            data_n    = data;
        end

        case (state)
            TX_IDLE: begin
                rails_n = '0;
                if (pending && e_s) begin
                    rails_n   = N'(1) << data_q;
                    pending_n = 1'b0;
                    state_n   = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (!e_s) begin
                    rails_n = '0;
                    state_n = TX_WAIT_EN;
                end
            end
            TX_WAIT_EN: begin
                rails_n = '0;
                if (e_s) begin
                    state_n = TX_IDLE;
                end
            end
            default: begin
                rails_n = '0;
                state_n = TX_IDLE;
            end
        endcase
    end
endmodule

// 1-of-2 -> binary receiver with sticky illegal-code detection
module qdi_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] rx,
    output logic       rxe,
    output logic       rx_data,
    output logic       rx_valid,
    output logic       rx_error
);
    typedef enum logic {
        RX_READY,
        RX_HOLD
    } rx_state_t;

    logic [1:0] rx_sync [SYNC_STAGES];
    logic [1:0] rx_s;
    rx_state_t  state, state_n;
    logic       rxe_n, data_n, valid_n, error_n;

    // Both rails go through their own synchronizer chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rx_sync[i] <= 2'b00;
            end
        end else begin
            rx_sync[0] <= rx;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rx_sync[i] <= rx_sync[i-1];
            end
        end
    end

    assign rx_s = rx_sync[SYNC_STAGES-1];

    // Receiver state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX_READY;
            rxe      <= 1'b1;
            rx_data  <= 1'b0;
            rx_valid <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            state    <= state_n;
            rxe      <= rxe_n;
            rx_data  <= data_n;
            rx_valid <= valid_n;
            rx_error <= error_n;
        end
    end

    // Accept one token per neutral-to-valid transition, release on neutral
    always_comb begin
        state_n = state;
        rxe_n   = rxe;
        data_n  = rx_data;
        valid_n = rx_valid;
        error_n = rx_error;

        case (state)
            RX_READY: begin
                case (rx_s)
                    2'b01: begin
                        data_n  = 1'b0;
                        valid_n = 1'b1;
                        rxe_n   = 1'b0;
                        state_n = RX_HOLD;
                    end
                    2'b10: begin
                        data_n  = 1'b1;
                        valid_n = 1'b1;
                        rxe_n   = 1'b0;
                        state_n = RX_HOLD;
                    end
                    2'b11: begin
                        error_n = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            RX_HOLD: begin
                if (rx_s == 2'b00) begin
                    valid_n = 1'b0;
                    rxe_n   = 1'b1;
                    state_n = RX_READY;
                end
            end
            default: begin
                state_n = RX_READY;
            end
        endcase
    end
endmodule

// Top level: three independent channels sharing clock and reset
module qdi_bin_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       TxData,
    input  logic       TxGo,
    input  logic       Txe,
    output logic [1:0] Tx,
    input  logic [1:0] CxData,
    input  logic       CxGo,
    input  logic       Cxe,
    output logic [3:0] Cx,
    input  logic [1:0] Rx,
    output logic       Rxe,
    output logic       RxData,
    output logic       RxValid,
    output logic       RxError,
    inout  wire        VDD,
    inout  wire        GND
);
    logic unused_supply;

    assign unused_supply = VDD ^ GND;

    qdi_tx #(.W(1), .SYNC_STAGES(SYNC_STAGES)) u_tx (
        .clk   (CLK),
        .rst_n (RESET),
        .data  (TxData),
        .go    (TxGo),
        .e     (Txe),
        .rails (Tx)
    );

    qdi_tx #(.W(2), .SYNC_STAGES(SYNC_STAGES)) u_cx (
        .clk   (CLK),
        .rst_n (RESET),
        .data  (CxData),
        .go    (CxGo),
        .e     (Cxe),
        .rails (Cx)
    );

    qdi_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk      (CLK),
        .rst_n    (RESET),
        .rx       (Rx),
        .rxe      (Rxe),
        .rx_data  (RxData),
        .rx_valid (RxValid),
        .rx_error (RxError)
    );
endmodule

// File: tb/tb_qdi_bin_bridge.sv
// tb_qdi_bin_bridge: directed sequence with randomized data for qdi_bin_bridge.
// Expected values come from the token rules: a value v lights rail v (2**v).
// The latency is SYNC_STAGES+1 edges for enable or rail changes.
module tb_qdi_bin_bridge;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       TxData = 1'b0;
    logic       TxGo = 1'b0;
    logic       txe_man = 1'b0;
    logic [1:0] CxData = 2'b00;
    logic       CxGo = 1'b0;
    logic       Cxe = 1'b0;
    logic [1:0] rx_man = 2'b00;
    logic       loop_en = 1'b0;

    wire  [1:0] Tx;
    wire  [3:0] Cx;
    wire        Rxe, RxData, RxValid, RxError;
    wire  [1:0] rx_drv;
    wire        txe_drv;
    wire        vdd, gnd;

    assign vdd     = 1'b1;
    assign gnd     = 1'b0;
    assign rx_drv  = loop_en ? Tx : rx_man;
    assign txe_drv = loop_en ? Rxe : txe_man;

    int total = 0;
    int bad = 0;

    int         tx_tokens = 0;
    int         cx_tokens = 0;
    int         rx_tokens = 0;
    int         cx_while_off = 0;
    int         multihot = 0;
    logic [1:0] tx_prev = 2'b00;
    logic [3:0] cx_prev = 4'b0000;
    logic       rxv_prev = 1'b0;

    qdi_bin_bridge #(.SYNC_STAGES(2)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .TxData  (TxData),
        .TxGo    (TxGo),
        .Txe     (txe_drv),
        .Tx      (Tx),
        .CxData  (CxData),
        .CxGo    (CxGo),
        .Cxe     (Cxe),
        .Cx      (Cx),
        .Rx      (rx_drv),
        .Rxe     (Rxe),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxError (RxError),
        .VDD     (vdd),
        .GND     (gnd)
    );

    // Free-running clock
    always #5 CLK = ~CLK;

    // Token counters and rail-sanity observers, sampled mid-cycle
    always @(negedge CLK) begin
        if (Tx != 2'b00 && tx_prev == 2'b00) tx_tokens++;
        if (Cx != 4'b0000 && cx_prev == 4'b0000) begin
            cx_tokens++;
            if (!Cxe) cx_while_off++;
        end
        if (RxValid && !rxv_prev) rx_tokens++;
        if ($countones(Tx) > 1 || $countones(Cx) > 1) multihot++;
        tx_prev  = Tx;
        cx_prev  = Cx;
        rxv_prev = RxValid;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Let the currently driven inputs act for a number of rising edges
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge CLK);
        #1;
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence
    initial begin
        int d;
        int prev;
        int n;
        int t0;
        int r0;
        logic [1:0] r;
        int q[$];

        #2;
        RESET = 1'b0;
        $display("[TB] reset with toggling inputs");
        for (int i = 0; i < 10; i++) begin
            rx_man  = 2'($urandom);
            txe_man = 1'($urandom);
            TxGo    = 1'($urandom);
            CxGo    = 1'($urandom);
            Cxe     = 1'($urandom);
            TxData  = 1'($urandom);
            CxData  = 2'($urandom);
            applyStimulus(1);
        end
        checkOutput("rst_tx", 8'(Tx), 8'h00);
        checkOutput("rst_cx", 8'(Cx), 8'h00);
        checkOutput("rst_rxe", 8'(Rxe), 8'h01);
        checkOutput("rst_rxvalid", 8'(RxValid), 8'h00);
        checkOutput("rst_rxerror", 8'(RxError), 8'h00);
        checkOutput("rst_rxdata", 8'(RxData), 8'h00);

        rx_man  = 2'b00;
        txe_man = 1'b1;
        TxGo    = 1'b0;
        CxGo    = 1'b0;
        Cxe     = 1'b0;
        TxData  = 1'b0;
        CxData  = 2'b00;
        applyStimulus(1);
        RESET = 1'b1;
        applyStimulus(3);

        $display("[TB] C channel: ten tokens with a 2-cycle enable responder");
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                d = 3;
                CxData = 2'(d);
                CxGo = 1'b1;
                applyStimulus(1);
                CxGo = 1'b0;
                CxData = 2'($urandom);
                applyStimulus(6);
                checkOutput("c_no_launch_disabled", 8'(Cx), 8'h00);
                Cxe = 1'b1;
                applyStimulus(2);
                checkOutput("c_enable_latency", 8'(Cx), 8'h00);
                applyStimulus(1);
                checkOutput("c_first_valid", 8'(Cx), 8'(2 ** d));
            end else begin
                d = (i % 2 == 0) ? 3 : int'($urandom_range(0, 3));
                CxData = 2'(d);
                CxGo = 1'b1;
                applyStimulus(1);
                checkOutput("c_pending", 8'(Cx), 8'h00);
                CxGo = 1'b0;
                CxData = 2'($urandom);
                applyStimulus(1);
                checkOutput("c_valid", 8'(Cx), 8'(2 ** d));
            end
            CxGo = (i % 2 == 1);
            applyStimulus(1);
            CxGo = 1'b0;
            applyStimulus(1);
            checkOutput("c_stable", 8'(Cx), 8'(2 ** d));
            Cxe = 1'b0;
            applyStimulus(2);
            checkOutput("c_ack_latency", 8'(Cx), 8'(2 ** d));
            applyStimulus(1);
            checkOutput("c_neutral", 8'(Cx), 8'h00);
            applyStimulus(2);
            Cxe = 1'b1;
            applyStimulus(4 + int'($urandom_range(0, 3)));
        end
        checkOutput("c_token_count", 8'(cx_tokens), 8'd10);
        checkOutput("c_while_disabled", 8'(cx_while_off), 8'd0);

        $display("[TB] T channel directed tokens");
        for (int j = 0; j < 4; j++) begin
            d = (j == 0) ? 1 : (j == 1) ? 0 : int'($urandom_range(0, 1));
            TxData = 1'(d);
            TxGo = 1'b1;
            applyStimulus(1);
            checkOutput("t_pending", 8'(Tx), 8'h00);
            TxGo = 1'b0;
            TxData = 1'($urandom);
            applyStimulus(1);
            checkOutput("t_valid", 8'(Tx), 8'(2 ** d));
            applyStimulus(3);
            checkOutput("t_stable", 8'(Tx), 8'(2 ** d));
            txe_man = 1'b0;
            applyStimulus(2);
            checkOutput("t_ack_latency", 8'(Tx), 8'(2 ** d));
            applyStimulus(1);
            checkOutput("t_neutral", 8'(Tx), 8'h00);
            txe_man = 1'b1;
            applyStimulus(4 + int'($urandom_range(0, 2)));
        end
        checkOutput("t_token_count", 8'(tx_tokens), 8'd4);

        $display("[TB] receiver directed tokens");
        r0 = rx_tokens;
        for (int j = 0; j < 4; j++) begin
            r = (j == 0) ? 2'b10 : (j == 1) ? 2'b01 :
                ($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01);
            d = (r == 2'b10) ? 1 : 0;
            rx_man = r;
            applyStimulus(2);
            checkOutput("r_latency", 8'(RxValid), 8'h00);
            applyStimulus(1);
            checkOutput("r_valid", 8'(RxValid), 8'h01);
            checkOutput("r_data", 8'(RxData), 8'(d));
            checkOutput("r_rxe_low", 8'(Rxe), 8'h00);
            applyStimulus(3);
            checkOutput("r_hold", 8'(RxValid), 8'h01);
            rx_man = 2'b00;
            applyStimulus(3);
            checkOutput("r_release", 8'(RxValid), 8'h00);
            checkOutput("r_rxe_high", 8'(Rxe), 8'h01);
            checkOutput("r_data_kept", 8'(RxData), 8'(d));
        end
        checkOutput("r_token_count", 8'(rx_tokens - r0), 8'd4);

        $display("[TB] receiver illegal code");
        rx_man = 2'b11;
        applyStimulus(4);
        checkOutput("r_err_set", 8'(RxError), 8'h01);
        checkOutput("r_err_novalid", 8'(RxValid), 8'h00);
        checkOutput("r_err_rxe", 8'(Rxe), 8'h01);
        rx_man = 2'b00;
        applyStimulus(4);
        checkOutput("r_err_sticky", 8'(RxError), 8'h01);
        checkOutput("r_err_novalid2", 8'(RxValid), 8'h00);

        $display("[TB] loopback: held go yields one token");
        loop_en = 1'b1;
        applyStimulus(4);
        t0 = tx_tokens;
        r0 = rx_tokens;
        d = int'($urandom_range(0, 1));
        TxData = 1'(d);
        TxGo = 1'b1;
        applyStimulus(40);
        checkOutput("lb_held_tx_tokens", 8'(tx_tokens - t0), 8'd1);
        checkOutput("lb_held_rx_tokens", 8'(rx_tokens - r0), 8'd1);
        checkOutput("lb_held_data", 8'(RxData), 8'(d));
        TxGo = 1'b0;
        applyStimulus(8);

        $display("[TB] loopback: ten alternating tokens");
        r0 = rx_tokens;
        prev = int'($urandom_range(0, 1));
        for (int i = 0; i < 10; i++) begin
            d = 1 - prev;
            prev = d;
            q.push_back(d);
            TxData = 1'(d);
            TxGo = 1'b1;
            applyStimulus(1);
            TxGo = 1'b0;
            n = 0;
            while (!RxValid && n < 20) begin
                applyStimulus(1);
                n++;
            end
            checkOutput("lb_valid", 8'(RxValid), 8'h01);
            checkOutput("lb_data", 8'(RxData), 8'(q.pop_front()));
            n = 0;
            while (RxValid && n < 20) begin
                applyStimulus(1);
                n++;
            end
            checkOutput("lb_release", 8'(RxValid), 8'h00);
            applyStimulus(6 + int'($urandom_range(0, 3)));
        end
        checkOutput("lb_token_count", 8'(rx_tokens - r0), 8'd10);

        $display("[TB] reset mid-flight");
        txe_man = 1'b1;
        rx_man = 2'b00;
        loop_en = 1'b0;
        applyStimulus(4);
        TxData = 1'b1;
        TxGo = 1'b1;
        applyStimulus(1);
        TxGo = 1'b0;
        applyStimulus(1);
        checkOutput("mf_valid", 8'(Tx), 8'h02);
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("mf_tx_cleared", 8'(Tx), 8'h00);
        checkOutput("mf_rxe", 8'(Rxe), 8'h01);
        checkOutput("mf_rxerror", 8'(RxError), 8'h00);
        checkOutput("mf_rxvalid", 8'(RxValid), 8'h00);
        applyStimulus(3);
        RESET = 1'b1;
        t0 = tx_tokens;
        applyStimulus(10);
        checkOutput("mf_no_resume", 8'(Tx), 8'h00);
        checkOutput("mf_no_token", 8'(tx_tokens - t0), 8'd0);
        checkOutput("rails_one_hot", 8'(multihot), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
